// File: rtl/uart_rx_os_if.sv
`default_nettype none
// ============================================================================
// Module   : uart_rx_os_if
// Purpose  : Byte-delivery handshake between the oversampling UART receiver
//            and the logic that consumes received bytes.
// Signals  : rx_data_o  - received byte, stable while rx_valid_o is high
//            rx_valid_o - byte available, held until accepted
//            rx_ready_i - consumer accepts when rx_valid_o && rx_ready_i
// Modports : master (receiver side), slave (consumer side)
// Revision : 1.0 - initial release
// ============================================================================
interface uart_rx_os_if #(
    parameter int DATA_BITS = 8
);
    logic [DATA_BITS-1:0] rx_data_o;
    logic                 rx_valid_o;
    logic                 rx_ready_i;

    modport master (
        output rx_data_o,
        output rx_valid_o,
        input  rx_ready_i
    );

    modport slave (
        input  rx_data_o,
        input  rx_valid_o,
        output rx_ready_i
    );
endinterface
`default_nettype wire

// File: rtl/uart_rx_os.sv
`default_nettype none
// ============================================================================
// Module   : uart_rx_os
// Purpose  : Oversampling 8N1 UART receiver. Synchronises the rx line,
//            detects and validates start bits, majority-votes each bit at
//            mid-bit and delivers bytes through a valid/ready holding register.
// Ports    : clk           - system clock
//            rst_n         - asynchronous active-low reset
//            rx_i          - serial line, idle high, asynchronous to clk
//            bus (master)  - rx_data_o / rx_valid_o / rx_ready_i handshake
//            frame_err_o   - one-cycle pulse, stop bit sampled low
//            overrun_err_o - one-cycle pulse, byte completed while still valid
//            busy_o        - high whenever the receiver is not idle
// Revision : 1.0 - initial release
// ============================================================================
module uart_rx_os #(
    parameter int BAUD_DIV  = 27,
    parameter int OSR       = 16,
    parameter int DATA_BITS = 8
) (
    input  wire logic    clk,
    input  wire logic    rst_n,
    input  wire logic    rx_i,
    uart_rx_os_if.master bus,
    output logic         frame_err_o,
    output logic         overrun_err_o,
    output logic         busy_o
);

    localparam int c_tick_w = (BAUD_DIV > 1) ? $clog2(BAUD_DIV) : 1;
    localparam int c_idx_w  = $clog2(DATA_BITS + 1);

    localparam logic [c_tick_w-1:0] c_tick_last = c_tick_w'(BAUD_DIV - 1);
    localparam logic [3:0]          c_samp_last = 4'(OSR - 1);
    localparam logic [c_idx_w-1:0]  c_bit_last  = c_idx_w'(DATA_BITS - 1);

    localparam logic [1:0] c_st_idle  = 2'd0;
    localparam logic [1:0] c_st_start = 2'd1;
    localparam logic [1:0] c_st_data  = 2'd2;
    localparam logic [1:0] c_st_stop  = 2'd3;

    logic                 r_sync1, r_sync2, r_rx_prev;
    logic [c_tick_w-1:0]  r_tick_cnt;
    logic [3:0]           r_samp_cnt;
    logic                 r_s7, r_s8;
    logic [c_idx_w-1:0]   r_bit_idx;
    logic [DATA_BITS-1:0] r_shift;
    logic [DATA_BITS-1:0] r_data;
    logic                 r_valid;
    logic                 r_ferr, r_ovr;
    logic [1:0]           r_state;

    logic                 w_fall, w_tick, w_eval, w_vote, w_accept;
    logic [1:0]           w_state_nxt;
    logic                 w_start, w_shift_en, w_stop_ok, w_stop_bad;
    logic [DATA_BITS:0]   w_cat;

    assign w_fall   = r_rx_prev & ~r_sync2;
    assign w_tick   = (r_tick_cnt == c_tick_last);
    assign w_eval   = w_tick && (r_samp_cnt == 4'd9);
    // Tick-9 sample is taken live from the synchroniser; ticks 7 and 8 were stored.
    assign w_vote   = (r_s7 & r_s8) | (r_s7 & r_sync2) | (r_s8 & r_sync2);
    assign w_accept = r_valid & bus.rx_ready_i;
    assign w_cat    = {w_vote, r_shift};

    // ---------------- FSM: state register ----------------
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) r_state <= c_st_idle;
        else        r_state <= w_state_nxt;
    end

    // ---------------- FSM: next state ----------------
    always_comb begin
        w_state_nxt = r_state;
        case (r_state)
            c_st_idle:  if (w_fall) w_state_nxt = c_st_start;
            c_st_start: if (w_eval) w_state_nxt = w_vote ? c_st_idle : c_st_data;
            c_st_data:  if (w_eval && (r_bit_idx == c_bit_last)) w_state_nxt = c_st_stop;
            c_st_stop:  if (w_eval) w_state_nxt = c_st_idle;
            default:    w_state_nxt = c_st_idle;
        endcase
    end

    // ---------------- FSM: outputs / strobes ----------------
    always_comb begin
        busy_o     = (r_state != c_st_idle);
        w_start    = (r_state == c_st_idle) && w_fall;
        w_shift_en = (r_state == c_st_data) && w_eval;
        w_stop_ok  = (r_state == c_st_stop) && w_eval && w_vote;
        w_stop_bad = (r_state == c_st_stop) && w_eval && !w_vote;
    end

    // ---------------- Datapath ----------------
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            r_sync1    <= 1'b1;
            r_sync2    <= 1'b1;
            r_rx_prev  <= 1'b1;
            r_tick_cnt <= '0;
            r_samp_cnt <= 4'd0;
            r_s7       <= 1'b1;
            r_s8       <= 1'b1;
            r_bit_idx  <= '0;
            r_shift    <= '0;
            r_data     <= '0;
            r_valid    <= 1'b0;
            r_ferr     <= 1'b0;
            r_ovr      <= 1'b0;
        end else begin
            r_sync1   <= rx_i;
            r_sync2   <= r_sync1;
            r_rx_prev <= r_sync2;

            // Restarting on the start edge aligns the sampling phase to the edge.
            if (w_start || w_tick) r_tick_cnt <= '0;
            else                   r_tick_cnt <= r_tick_cnt + 1'b1;

            if (w_start)
                r_samp_cnt <= 4'd0;
            else if (busy_o && w_tick)
                r_samp_cnt <= (r_samp_cnt == c_samp_last) ? 4'd0 : r_samp_cnt + 4'd1;

            if (w_tick && (r_samp_cnt == 4'd7)) r_s7 <= r_sync2;
            if (w_tick && (r_samp_cnt == 4'd8)) r_s8 <= r_sync2;

            if (w_start)         r_bit_idx <= '0;
            else if (w_shift_en) r_bit_idx <= r_bit_idx + 1'b1;

            // LSB first: each vote enters at the top and walks down to bit 0.
            if (w_shift_en) r_shift <= w_cat[DATA_BITS:1];

            // A completion in the same clock as an accept reloads without overrun.
            if (w_stop_ok && (!r_valid || w_accept)) begin
                r_data  <= r_shift;
                r_valid <= 1'b1;
            end else if (w_accept) begin
                r_valid <= 1'b0;
            end

            r_ovr  <= w_stop_ok && r_valid && !w_accept;
            r_ferr <= w_stop_bad;
        end
    end

    assign bus.rx_data_o  = r_data;
    assign bus.rx_valid_o = r_valid;
    assign frame_err_o    = r_ferr;
    assign overrun_err_o  = r_ovr;

endmodule
`default_nettype wire

// File: tb/tb_uart_rx_os.sv
`default_nettype none
// ============================================================================
// Module   : tb_uart_rx_os
// Purpose  : Self-checking bench for uart_rx_os at BAUD_DIV=2 (32 clocks/bit).
//            Table of single frames plus hand-written multi-frame sequences.
// Revision : 1.0 - initial release
// ============================================================================
module tb_uart_rx_os;

    localparam int BIT_CLKS = 32;

    logic clk   = 1'b0;
    logic rst_n = 1'b0;
    logic rx    = 1'b1;
    logic ferr, ovr, busy;

    always #5 clk = ~clk;

    uart_rx_os_if #(.DATA_BITS(8)) bus ();

    uart_rx_os #(
        .BAUD_DIV  (2),
        .OSR       (16),
        .DATA_BITS (8)
    ) dut (
        .clk           (clk),
        .rst_n         (rst_n),
        .rx_i          (rx),
        .bus           (bus),
        .frame_err_o   (ferr),
        .overrun_err_o (ovr),
        .busy_o        (busy)
    );

    int n_checks = 0;
    int n_fail   = 0;

    // Pulse/event counters sampled away from the active edge.
    int   ferr_total = 0;
    int   ovr_total  = 0;
    int   busy_rise  = 0;
    logic busy_q     = 1'b0;
    always @(negedge clk) begin
        if (ferr === 1'b1) ferr_total++;
        if (ovr === 1'b1)  ovr_total++;
        if (busy === 1'b1 && busy_q !== 1'b1) busy_rise++;
        busy_q = busy;
    end

    task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
        n_checks++;
        if (act !== exp) begin
            n_fail++;
            $display("FAIL %s: got %0h expected %0h", name, act, exp);
        end
    endtask

    task automatic wait_clks(input int n);
        repeat (n) @(posedge clk);
        #1;
    endtask

    // Drives one 8N1 frame; spike_bit (frame bit index, -1 none) gets a
    // 2-clock inversion at its tick-8 sampling point.
    task automatic send_frame(input logic [7:0] d, input logic stop, input int spike_bit);
        logic [9:0] bits;
        bits = {stop, d, 1'b0};
        for (int b = 0; b < 10; b++) begin
            for (int c = 0; c < BIT_CLKS; c++) begin
                rx = bits[b];
                if (b == spike_bit && (c == 18 || c == 19)) rx = ~bits[b];
                wait_clks(1);
            end
        end
        rx = 1'b1;
    endtask

    typedef struct {
        logic [7:0] data;
        logic       stop;
        int         spike;
        logic       exp_valid;
        logic [7:0] exp_data;
        int         exp_ferr;
    } vec_t;

    vec_t vecs [6];

    initial begin
        int f0, o0, b0;
        logic [9:0] pbits;

        vecs[0] = '{8'h55, 1'b1, -1, 1'b1, 8'h55, 0};
        vecs[1] = '{8'hA3, 1'b0, -1, 1'b0, 8'h55, 1};
        vecs[2] = '{8'h0F, 1'b1,  3, 1'b1, 8'h0F, 0};
        vecs[3] = '{8'h00, 1'b1, -1, 1'b1, 8'h00, 0};
        vecs[4] = '{8'hFF, 1'b1, -1, 1'b1, 8'hFF, 0};
        vecs[5] = '{8'h80, 1'b0, -1, 1'b0, 8'hFF, 1};

        bus.rx_ready_i = 1'b0;
        wait_clks(3);
        check("reset_valid", 32'(bus.rx_valid_o), 32'd0);
        check("reset_data",  32'(bus.rx_data_o),  32'd0);
        check("reset_busy",  32'(busy), 32'd0);
        check("reset_ferr",  32'(ferr), 32'd0);
        check("reset_ovr",   32'(ovr),  32'd0);
        rst_n = 1'b1;
        wait_clks(10);

        // ---------------- table-driven single frames ----------------
        for (int i = 0; i < 6; i++) begin
            f0 = ferr_total;
            o0 = ovr_total;
            send_frame(vecs[i].data, vecs[i].stop, vecs[i].spike);
            wait_clks(4);
            check($sformatf("v%0d_valid", i), 32'(bus.rx_valid_o), 32'(vecs[i].exp_valid));
            check($sformatf("v%0d_data", i),  32'(bus.rx_data_o),  32'(vecs[i].exp_data));
            check($sformatf("v%0d_ferr", i),  32'(ferr_total - f0), 32'(vecs[i].exp_ferr));
            check($sformatf("v%0d_ovr", i),   32'(ovr_total - o0),  32'd0);
            check($sformatf("v%0d_busy", i),  32'(busy), 32'd0);
            if (vecs[i].exp_valid) begin
                wait_clks(40);
                check($sformatf("v%0d_held", i), 32'(bus.rx_valid_o), 32'd1);
                bus.rx_ready_i = 1'b1;
                #1;
                check($sformatf("v%0d_valid_at_accept", i), 32'(bus.rx_valid_o), 32'd1);
                wait_clks(1);
                bus.rx_ready_i = 1'b0;
                check($sformatf("v%0d_cleared", i), 32'(bus.rx_valid_o), 32'd0);
            end
            wait_clks(20);
        end

        // ---------------- 6-clock low glitch: false start ----------------
        f0 = ferr_total;
        o0 = ovr_total;
        b0 = busy_rise;
        rx = 1'b0;
        wait_clks(6);
        rx = 1'b1;
        wait_clks(40);
        check("glitch_busy_pulsed", 32'(busy_rise - b0), 32'd1);
        check("glitch_busy_now",    32'(busy), 32'd0);
        check("glitch_valid",       32'(bus.rx_valid_o), 32'd0);
        check("glitch_ferr",        32'(ferr_total - f0), 32'd0);
        check("glitch_ovr",         32'(ovr_total - o0), 32'd0);

        // ---------------- back-to-back with no accept: overrun ----------------
        f0 = ferr_total;
        o0 = ovr_total;
        send_frame(8'h12, 1'b1, -1);
        send_frame(8'h34, 1'b1, -1);
        wait_clks(4);
        check("b2b_valid", 32'(bus.rx_valid_o), 32'd1);
        check("b2b_data",  32'(bus.rx_data_o),  32'h12);
        check("b2b_ovr",   32'(ovr_total - o0), 32'd1);
        check("b2b_ferr",  32'(ferr_total - f0), 32'd0);

        // ---------------- reset in the middle of data bit 4 ----------------
        pbits = {1'b1, 8'h5A, 1'b0};
        for (int c = 0; c < 5 * BIT_CLKS + 16; c++) begin
            rx = pbits[c / BIT_CLKS];
            wait_clks(1);
        end
        check("pre_rst_busy", 32'(busy), 32'd1);
        rst_n = 1'b0;
        #1;
        check("rst_valid", 32'(bus.rx_valid_o), 32'd0);
        check("rst_data",  32'(bus.rx_data_o),  32'd0);
        check("rst_busy",  32'(busy), 32'd0);
        check("rst_ferr",  32'(ferr), 32'd0);
        check("rst_ovr",   32'(ovr),  32'd0);
        rx = 1'b1;
        wait_clks(5);
        rst_n = 1'b1;
        wait_clks(5);
        f0 = ferr_total;
        o0 = ovr_total;
        send_frame(8'hC3, 1'b1, -1);
        wait_clks(4);
        check("post_rst_valid", 32'(bus.rx_valid_o), 32'd1);
        check("post_rst_data",  32'(bus.rx_data_o),  32'hC3);
        check("post_rst_ferr",  32'(ferr_total - f0), 32'd0);
        check("post_rst_ovr",   32'(ovr_total - o0), 32'd0);

        $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
        $finish;
    end

endmodule
`default_nettype wire
